// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, the ignore list and the decoder FSM
// state type for the PS/2 key sequencer.
package ps2_pkg;

  // Prefix and special scan codes (set 2)
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Keyboard housekeeping bytes that carry no key information
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  // ASCII pushed for keypad enter
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_e;

  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {SC_ACK, SC_BAT_OK, SC_ECHO, SC_PAUSE, SC_ERR_LO, SC_ERR_HI};
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational US-layout scan-code (set 2) to ASCII map.
// Unmapped codes return 8'h00. Letters report is_letter so the caller can
// fold caps lock into the case selection.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       is_letter
);

  logic [7:0] lo_c;
  logic [7:0] hi_c;

  // Look up unshifted and shifted characters for the code
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    lo_c = 8'h00;
    hi_c = 8'h00;
    case (code)
      // letters: only the lower case is listed, upper derived below
      8'h1C: lo_c = "a";  8'h32: lo_c = "b";  8'h21: lo_c = "c";
      8'h23: lo_c = "d";  8'h24: lo_c = "e";  8'h2B: lo_c = "f";
      8'h34: lo_c = "g";  8'h33: lo_c = "h";  8'h43: lo_c = "i";
      8'h3B: lo_c = "j";  8'h42: lo_c = "k";  8'h4B: lo_c = "l";
      8'h3A: lo_c = "m";  8'h31: lo_c = "n";  8'h44: lo_c = "o";
      8'h4D: lo_c = "p";  8'h15: lo_c = "q";  8'h2D: lo_c = "r";
      8'h1B: lo_c = "s";  8'h2C: lo_c = "t";  8'h3C: lo_c = "u";
      8'h2A: lo_c = "v";  8'h1D: lo_c = "w";  8'h22: lo_c = "x";
      8'h35: lo_c = "y";  8'h1A: lo_c = "z";
      // digit row
      8'h45: begin lo_c = "0"; hi_c = ")"; end
      8'h16: begin lo_c = "1"; hi_c = "!"; end
      8'h1E: begin lo_c = "2"; hi_c = "@"; end
      8'h26: begin lo_c = "3"; hi_c = "#"; end
      8'h25: begin lo_c = "4"; hi_c = "$"; end
      8'h2E: begin lo_c = "5"; hi_c = "%"; end
      8'h36: begin lo_c = "6"; hi_c = "^"; end
      8'h3D: begin lo_c = "7"; hi_c = "&"; end
      8'h3E: begin lo_c = "8"; hi_c = "*"; end
      8'h46: begin lo_c = "9"; hi_c = "("; end
      // punctuation
      8'h4E: begin lo_c = "-";   hi_c = "_"; end
      8'h55: begin lo_c = "=";   hi_c = "+"; end
      8'h54: begin lo_c = "[";   hi_c = "{"; end
      8'h5B: begin lo_c = "]";   hi_c = "}"; end
      8'h5D: begin lo_c = "\\";  hi_c = "|"; end
      8'h4C: begin lo_c = ";";   hi_c = ":"; end
      8'h52: begin lo_c = "'";   hi_c = "\""; end
      8'h41: begin lo_c = ",";   hi_c = "<"; end
      8'h49: begin lo_c = ".";   hi_c = ">"; end
      8'h4A: begin lo_c = "/";   hi_c = "?"; end
      8'h0E: begin lo_c = 8'h60; hi_c = "~"; end
      // whitespace and control keys are case independent
      8'h29: begin lo_c = 8'h20; hi_c = 8'h20; end
      8'h5A: begin lo_c = 8'h0A; hi_c = 8'h0A; end
      8'h66: begin lo_c = 8'h08; hi_c = 8'h08; end
      8'h0D: begin lo_c = 8'h09; hi_c = 8'h09; end
      8'h76: begin lo_c = 8'h1B; hi_c = 8'h1B; end
      default: begin
        lo_c = 8'h00;
        hi_c = 8'h00;
      end
    endcase
    if (lo_c inside {[8'h61:8'h7A]}) begin
      hi_c = lo_c - 8'h20;
    end
  end

  assign is_letter = (lo_c inside {[8'h61:8'h7A]});
  assign ascii     = upper ? hi_c : lo_c;

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: decodes a PS/2 scan-code byte stream (make, F0 break,
// E0 extended), tracks shift/caps state, suppresses typematic repeats and
// queues the resulting ASCII characters in a valid/ready FIFO.
// Optional build macro PS2_CAPS_LOCK_EN enables the caps-lock toggle on 58.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter bit REPEAT_SUPPRESS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   scan_code,
  input  logic                         scan_valid,
  output logic [7:0]                   ascii_data,
  output logic                         ascii_valid,
  input  logic                         ascii_ready,
  output logic                         shift_active,
  output logic                         caps_active,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------- decoder
  state_e     state_q,     state_d;
  logic       lshift_q,    lshift_d;
  logic       rshift_q,    rshift_d;
  logic [7:0] last_make_q, last_make_d;
  logic       push_q,      push_d;
  logic [7:0] push_char_q, push_char_d;

  logic [7:0] map_ascii;
  logic       map_letter;
  logic       map_upper;
  logic       is_repeat;

`ifdef PS2_CAPS_LOCK_EN
  logic caps_q, caps_d;
  assign caps_active = caps_q;
`else
  assign caps_active = 1'b0;
`endif

  assign shift_active = lshift_q | rshift_q;
  assign map_upper    = map_letter ? (shift_active ^ caps_active) : shift_active;
  assign is_repeat    = REPEAT_SUPPRESS && (scan_code == last_make_q);

  ps2_keymap u_keymap (
    .code      (scan_code),
    .upper     (map_upper),
    .ascii     (map_ascii),
    .is_letter (map_letter)
  );

  // Next-state and push decision for the byte presented this cycle
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    last_make_d = last_make_q;
    push_d      = 1'b0;
    push_char_d = 8'h00;
`ifdef PS2_CAPS_LOCK_EN
    caps_d      = caps_q;
`endif
    if (scan_valid) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = S_BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = S_EXT;
          end else if (scan_code == SC_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (scan_code == SC_RSHIFT) begin
            rshift_d = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
          end else if (scan_code == SC_CAPS) begin
            // holding caps lock re-sends the make; toggle only on the first
            if (!is_repeat) caps_d = ~caps_q;
            last_make_d = scan_code;
`endif
          end else if (!is_ignored(scan_code)) begin
            if ((map_ascii != 8'h00) && !is_repeat) begin
              push_d      = 1'b1;
              push_char_d = map_ascii;
            end
            last_make_d = scan_code;
          end
        end
        S_BREAK: begin
          if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
          if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
          if (scan_code == last_make_q) last_make_d = 8'h00;
          state_d = S_IDLE;
        end
        S_EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = S_EXT_BREAK;
          end else begin
            if (scan_code == SC_ENTER) begin
              push_d      = 1'b1;
              push_char_d = ASCII_LF;
            end
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decoder state and the one-stage push pipeline register
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      last_make_q <= 8'h00;
      push_q      <= 1'b0;
      push_char_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      last_make_q <= last_make_d;
      push_q      <= push_d;
      push_char_q <= push_char_d;
    end
  end

`ifdef PS2_CAPS_LOCK_EN
  // Caps-lock latch
  always_ff @(posedge clk) begin
    if (rst) caps_q <= 1'b0;
    else     caps_q <= caps_d;
  end
`endif

  // ------------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_push;
  logic          do_pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign do_pop     = !fifo_empty && ascii_ready;
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign do_push    = push_q && (!fifo_full || do_pop);

  assign ascii_valid = !fifo_empty;
  assign ascii_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

  // Character storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the empty flag masks stale contents.
    if (do_push) mem_q[wr_ptr_q] <= push_char_q;
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (push_q && !do_push) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed self-checking bench for ps2_key_sequencer.
// A second instance with REPEAT_SUPPRESS = 0 shares the scan stream.
module tb_ps2_key_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ready;
  logic       ready_nr;

  logic [7:0] ascii_data,   ascii_data_nr;
  logic       ascii_valid,  ascii_valid_nr;
  logic       shift_active, shift_active_nr;
  logic       caps_active,  caps_active_nr;
  logic       overflow,     overflow_nr;
  logic [3:0] fifo_count,   fifo_count_nr;

  int n_checks = 0;
  int n_pass   = 0;

  ps2_key_sequencer #(.FIFO_DEPTH(8), .REPEAT_SUPPRESS(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .ascii_data   (ascii_data),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ready),
    .shift_active (shift_active),
    .caps_active  (caps_active),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  ps2_key_sequencer #(.FIFO_DEPTH(8), .REPEAT_SUPPRESS(1'b0)) dut_nr (
    .clk          (clk),
    .rst          (rst),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .ascii_data   (ascii_data_nr),
    .ascii_valid  (ascii_valid_nr),
    .ascii_ready  (ready_nr),
    .shift_active (shift_active_nr),
    .caps_active  (caps_active_nr),
    .overflow     (overflow_nr),
    .fifo_count   (fifo_count_nr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // all tasks start and end on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic do_reset();
    ready    = 1'b0;
    ready_nr = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    int k;
    k = 0;
    while (!ascii_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, ascii_valid, 1'b1);
    check({tag, "_data"}, ascii_data, exp);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    ready      = 1'b0;
    ready_nr   = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    do_reset();
    idle(1);

    // reset state
    check("rst_valid",    ascii_valid,  1'b0);
    check("rst_data",     ascii_data,   8'h00);
    check("rst_overflow", overflow,     1'b0);
    check("rst_count",    fifo_count,   4'd0);
    check("rst_shift",    shift_active, 1'b0);
    check("rst_caps",     caps_active,  1'b0);

    // single key press/release, latency and pop
    send(8'h1C);
    check("lat_before", ascii_valid, 1'b0);
    @(negedge clk);
    check("lat_after", ascii_valid, 1'b1);
    check("lat_data",  ascii_data,  8'h61);
    send(8'hF0);
    send(8'h1C);
    idle(1);
    check("one_char_count", fifo_count, 4'd1);
    pop("a_pop", 8'h61);
    check("after_pop_count", fifo_count,  4'd0);
    check("after_pop_valid", ascii_valid, 1'b0);
    check("after_pop_data",  ascii_data,  8'h00);

    // shift handling
    do_reset();
    send(8'h12);
    check("shift_on", shift_active, 1'b1);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    check("shift_held", shift_active, 1'b1);
    send(8'hF0);
    send(8'h12);
    check("shift_off", shift_active, 1'b0);
    send(8'h32);
    idle(1);
    check("shift_count", fifo_count, 4'd2);
    pop("shift_A", 8'h41);
    pop("shift_b", 8'h62);

    // repeat suppression on and off
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
    idle(1);
    check("rep_count",    fifo_count,    4'd2);
    check("norep_count",  fifo_count_nr, 4'd4);
    pop("rep_first",  8'h61);
    pop("rep_second", 8'h61);
    check("rep_empty", fifo_count, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("norep_%0d", i), ascii_data_nr, 8'h61);
      ready_nr = 1'b1;
      @(negedge clk);
      ready_nr = 1'b0;
    end
    check("norep_empty", fifo_count_nr, 4'd0);

    // extended codes and ignore list
    do_reset();
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h1C);
    send(8'hFA); send(8'hAA);
    idle(1);
    check("ext_count", fifo_count, 4'd1);
    pop("ext_enter", 8'h0A);
    check("ext_empty", fifo_count, 4'd0);
    send(8'h1C);
    pop("ext_idle_a", 8'h61);

    // FIFO full, simultaneous push+pop at full, overflow, drain in order
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send(8'h24); send(8'h2B); send(8'h34); send(8'h33);
    idle(1);
    check("full_count",    fifo_count, 4'd8);
    check("full_no_ovf",   overflow,   1'b0);
    check("full_head",     ascii_data, 8'h61);
    scan_code  = 8'h3B;             // 'j' arrives while 'a' is popped
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    ready      = 1'b1;
    @(negedge clk);
    ready      = 1'b0;
    check("pp_count",  fifo_count, 4'd8);
    check("pp_no_ovf", overflow,   1'b0);
    send(8'h43);                    // 'i' is dropped
    idle(1);
    check("ovf_count", fifo_count, 4'd8);
    check("ovf_set",   overflow,   1'b1);
    drain_exp = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6A};
    for (int i = 0; i < 8; i++) pop($sformatf("drain_%0d", i), drain_exp[i]);
    ready = 1'b1;                   // pop requests on an empty FIFO
    idle(2);
    ready = 1'b0;
    check("empty_pop_count", fifo_count,  4'd0);
    check("empty_pop_valid", ascii_valid, 1'b0);
    check("empty_pop_data",  ascii_data,  8'h00);
    check("ovf_sticky",      overflow,    1'b1);
    do_reset();
    check("ovf_cleared", overflow, 1'b0);

`ifdef PS2_CAPS_LOCK_EN
    // caps lock toggles once per press and flips letter case only
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_on", caps_active, 1'b1);
    send(8'h1C); send(8'h16);
    pop("caps_A", 8'h41);
    pop("caps_1", 8'h31);
    send(8'h12); send(8'h1C);
    pop("caps_shift_a", 8'h61);
`else
    // without caps support 58 is an unmapped make
    send(8'h58);
    idle(1);
    check("nocaps_count", fifo_count,  4'd0);
    check("nocaps_flag",  caps_active, 1'b0);
`endif

    // reset in the middle of a break sequence
    send(8'h12);
    send(8'hF0);
    do_reset();
    check("midrst_shift", shift_active, 1'b0);
    check("midrst_caps",  caps_active,  1'b0);
    send(8'h1C);
    pop("midrst_a", 8'h61);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
